ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  EX-stage multiply/divide unit. Consumes aluop/reg1/reg2 from the ID/EX pipeline register.
//  Produces the HI/LO write for MULT(U), MADD(U), MSUB(U) and DIV(U).
//  Multi-cycle ops raise stallreq_o to the stall controller. This holds IF..EX until the result is ready.
// PARAMETERS
//  DIV_ITER  32  divider iterations, one quotient bit per cycle; must equal the data width
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-high (`RstEnable)
//  aluop_i      in   8   AluOp_t from ID/EX; held stable by the pipeline while stallreq_o=1
//  reg1_i       in   32  rs operand (forwarded): multiplicand / dividend
//  reg2_i       in   32  rt operand (forwarded): multiplier / divisor
//  hi_i         in   32  current HI, already forwarded from MEM/WB
//  lo_i         in   32  current LO, already forwarded from MEM/WB
//  annul_i      in   1   flush of the EX op; aborts any in-flight op
//  hi_o         out  32  HI result
//  lo_o         out  32  LO result
//  whilo_o      out  1   HI/LO write enable toward MEM
//  stallreq_o   out  1   pipeline stall request
// BEHAVIOUR
//  Reset (async)
//   - State goes to IDLE.
//   - hi_o, lo_o, whilo_o and stallreq_o are all 0.
//   - Internal counter, remainder and product registers are cleared.
//  State machine
//   - States: IDLE, MACC, DIV_ON, DIV_END.
//   - Outputs are combinational from state, registered data and inputs.
//  IDLE, MULT/MULTU
//   - Signed or unsigned 32x32 product; {hi_o,lo_o} = product, whilo_o=1, stallreq_o=0.
//   - Same cycle, no state change.
//  IDLE, MADD/MADDU/MSUB/MSUBU
//   - Product is registered into prod_r; stallreq_o=1, whilo_o=0; next state MACC.
//  MACC
//   - {hi_o,lo_o} = {hi_i,lo_i} + prod_r for MADD*, {hi_i,lo_i} - prod_r for MSUB*.
//   - 64-bit modulo arithmetic.
//   - whilo_o=1, stallreq_o=0; next state IDLE.
//   - Uses hi_i/lo_i sampled in this cycle, so an older HI/LO write in MEM/WB is honoured.
//  IDLE, DIV/DIVU, reg2_i != 0
//   - Capture |dividend| and |divisor| (DIVU: raw values), plus the sign flags.
//   - Clear the counter; stallreq_o=1; next state DIV_ON.
//  IDLE, DIV/DIVU, reg2_i == 0
//   - Quotient and remainder are forced to 0; stallreq_o=1; next state DIV_END.
//  DIV_ON
//   - Restoring division, 1 bit per cycle; stallreq_o=1.
//   - Each cycle: shift the {rem,quo} 65-bit register left by 1.
//   - If rem >= divisor: subtract the divisor from rem and set the quotient LSB.
//   - Counter goes 0..DIV_ITER-1; after the DIV_ITER-th iteration, next state DIV_END.
//  DIV_END
//   - lo_o = quotient, hi_o = remainder, whilo_o=1, stallreq_o=0; next state IDLE unconditionally.
//   - Signed fixup: quotient is negated if the operand signs differ.
//   - Signed fixup: remainder takes the dividend's sign.
//   - Stall is released here, so the next op arrives in IDLE; there is no re-trigger.
//  Latency
//   - DIV: 33 stalled cycles, result in the 34th cycle.
//   - Divide-by-0: 1 stalled cycle.
//   - MADD/MSUB: 1 stalled cycle.
//  annul_i=1 in any state
//   - whilo_o=0, stallreq_o=0; next state IDLE; the partial result is discarded.
//   - annul_i has priority over every other transition.
//  Signed boundary
//   - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
//  Any other aluop_i in IDLE
//   - whilo_o=0, stallreq_o=0, hi_o=lo_o=0.
//  aluop_i is ignored outside IDLE; the latched op type controls MACC and DIV_END.
// TESTING
//  1. MULT reg1=0xFFFFFFFF, reg2=2
//     -> same cycle: HI=0xFFFFFFFF, LO=0xFFFFFFFE, whilo=1, no stall.
//  2. MADDU hi_i=0, lo_i=0xFFFFFFFF, reg1=1, reg2=1
//     -> stall 1 cycle, then HI=1, LO=0, whilo=1.
//  3. DIV reg1=7, reg2=0xFFFFFFFE (-2)
//     -> stallreq high for 33 cycles.
//     -> 34th cycle: LO=0xFFFFFFFD, HI=1, whilo=1.
//  4. DIVU reg1=100, reg2=0
//     -> 1 stall cycle, then HI=LO=0, whilo=1.
//  5. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//  6. annul_i at DIV_ON iteration 10 -> whilo stays 0, stallreq drops, IDLE next cycle.
//     rst pulse mid-DIV, asynchronous to clk -> all outputs 0 immediately.
//     New MULT after either abort completes normally.

Source files
------------

// File: rtl/ex_muldiv.sv
// EX-stage multiply/divide unit: single-cycle MULT(U), two-cycle MADD/MSUB(U),
// and a restoring DIV(U) that produces one quotient bit per cycle.
module ex_muldiv #(
    parameter int unsigned DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [31:0] hi_i,
    input  logic [31:0] lo_i,
    input  logic        annul_i,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        whilo_o,
    output logic        stallreq_o
);

    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [7:0] OP_MADD  = 8'b1010_0110;
    localparam logic [7:0] OP_MADDU = 8'b1010_1000;
    localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
    localparam logic [7:0] OP_MSUBU = 8'b1010_1011;

    localparam int unsigned CW = $clog2(DIV_ITER);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_ITER - 1);

    typedef enum logic [1:0] {IDLE, MACC, DIV_ON, DIV_END} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic [63:0]   dreg;      // {remainder, quotient}
    logic [31:0]   divisor;
    logic          neg_quo, neg_rem;
    logic [63:0]   prod_r;
    logic          is_msub;

    logic          load_prod, load_div, zero_div, step_div;
    logic          op_signed;
    logic [63:0]   prod;
    logic [31:0]   dividend_abs, divisor_abs;
    logic [64:0]   shifted;
    logic          ge;
    logic [31:0]   diff;
    logic [63:0]   dreg_nxt;
    logic [63:0]   acc;

    assign op_signed = (aluop_i == OP_MULT) || (aluop_i == OP_MADD) ||
                       (aluop_i == OP_MSUB) || (aluop_i == OP_DIV);

    assign prod = op_signed
                ? {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i}
                : {32'h0, reg1_i} * {32'h0, reg2_i};

    assign dividend_abs = (op_signed && reg1_i[31]) ? -reg1_i : reg1_i;
    assign divisor_abs  = (op_signed && reg2_i[31]) ? -reg2_i : reg2_i;

    // Remainder is compared at 33 bits after the shift; the difference always fits in 32.
    assign shifted  = {dreg, 1'b0};
    assign ge       = shifted[64:32] >= {1'b0, divisor};
    assign diff     = shifted[63:32] - divisor;
    assign dreg_nxt = ge ? {diff, shifted[31:1], 1'b1} : shifted[63:0];

    assign acc = is_msub ? ({hi_i, lo_i} - prod_r) : ({hi_i, lo_i} + prod_r);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        hi_o       = '0;
        lo_o       = '0;
        whilo_o    = 1'b0;
        stallreq_o = 1'b0;
        load_prod  = 1'b0;
        load_div   = 1'b0;
        zero_div   = 1'b0;
        step_div   = 1'b0;
        if (rst || annul_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    case (aluop_i)
                        OP_MULT, OP_MULTU: begin
                            {hi_o, lo_o} = prod;
                            whilo_o      = 1'b1;
                        end
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            stallreq_o = 1'b1;
                            load_prod  = 1'b1;
                            state_nxt  = MACC;
                        end
                        OP_DIV, OP_DIVU: begin
                            stallreq_o = 1'b1;
                            if (reg2_i == '0) begin
                                zero_div  = 1'b1;
                                state_nxt = DIV_END;
                            end else begin
                                load_div  = 1'b1;
                                state_nxt = DIV_ON;
                            end
                        end
                        default: ;
                    endcase
                end
                MACC: begin
                    {hi_o, lo_o} = acc;
                    whilo_o      = 1'b1;
                    state_nxt    = IDLE;
                end
                DIV_ON: begin
                    stallreq_o = 1'b1;
                    step_div   = 1'b1;
                    if (cnt == CNT_LAST) state_nxt = DIV_END;
                end
                DIV_END: begin
                    lo_o      = neg_quo ? -dreg[31:0]  : dreg[31:0];
                    hi_o      = neg_rem ? -dreg[63:32] : dreg[63:32];
                    whilo_o   = 1'b1;
                    state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            dreg    <= '0;
            divisor <= '0;
            neg_quo <= 1'b0;
            neg_rem <= 1'b0;
            prod_r  <= '0;
            is_msub <= 1'b0;
        end else begin
            if (load_prod) begin
                prod_r  <= prod;
                is_msub <= (aluop_i == OP_MSUB) || (aluop_i == OP_MSUBU);
            end
            if (load_div) begin
                dreg    <= {32'h0, dividend_abs};
                divisor <= divisor_abs;
                cnt     <= '0;
                neg_quo <= op_signed && (reg1_i[31] ^ reg2_i[31]);
                neg_rem <= op_signed && reg1_i[31];
            end
            if (zero_div) begin
                dreg    <= '0;
                neg_quo <= 1'b0;
                neg_rem <= 1'b0;
            end
            if (step_div) begin
                dreg <= dreg_nxt;
                cnt  <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: table of single operations with hand-computed
// results and stall counts, plus annul and asynchronous-reset abort sequences.
module tb_ex_muldiv;

    localparam logic [7:0] OP_NOP   = 8'h00;
    localparam logic [7:0] OP_MULT  = 8'b0001_1000;
    localparam logic [7:0] OP_MULTU = 8'b0001_1001;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [7:0] OP_MADD  = 8'b1010_0110;
    localparam logic [7:0] OP_MADDU = 8'b1010_1000;
    localparam logic [7:0] OP_MSUB  = 8'b1010_1010;
    localparam logic [7:0] OP_MSUBU = 8'b1010_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop;
    logic [31:0] reg1, reg2, hi_in, lo_in;
    logic        annul;
    logic [31:0] hi, lo;
    logic        whilo, stallreq;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic [7:0]  op;
        logic [31:0] r1, r2, hi_in, lo_in;
        logic [31:0] ehi, elo;
        logic        ew;
        int unsigned est;
    } vec_t;

    vec_t vecs[15];

    ex_muldiv #(.DIV_ITER(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .hi_i       (hi_in),
        .lo_i       (lo_in),
        .annul_i    (annul),
        .hi_o       (hi),
        .lo_o       (lo),
        .whilo_o    (whilo),
        .stallreq_o (stallreq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".whilo"}, 64'(whilo),    64'd0);
        check({tag, ".stall"}, 64'(stallreq), 64'd0);
        check({tag, ".hi"},    64'(hi),       64'd0);
        check({tag, ".lo"},    64'(lo),       64'd0);
    endtask

    // Entered and left just after a rising edge.
    task automatic apply(input vec_t v, input int idx);
        int unsigned stalls;
        string tag;
        tag   = $sformatf("vec%0d", idx);
        aluop = v.op; reg1 = v.r1; reg2 = v.r2; hi_in = v.hi_in; lo_in = v.lo_in;
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!stallreq) break;
            stalls++;
            if (stalls > 100) break;
            @(posedge clk); #1;
        end
        check({tag, ".stalls"}, 64'(stalls),  64'(v.est));
        check({tag, ".whilo"},  64'(whilo),   64'(v.ew));
        check({tag, ".hi"},     64'(hi),      64'(v.ehi));
        check({tag, ".lo"},     64'(lo),      64'(v.elo));
        @(posedge clk); #1;
        aluop = OP_NOP;
    endtask

    initial begin
        vecs[0]  = '{OP_MULT,  32'hFFFFFFFF, 32'h2,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 0};
        vecs[1]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h2,        32'h0, 32'h0,        32'h1,        32'hFFFFFFFE, 1'b1, 0};
        vecs[2]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h0, 32'h0,        32'h40000000, 32'h0,        1'b1, 0};
        vecs[3]  = '{OP_MULTU, 32'h00010000, 32'h00010000, 32'h0, 32'h0,        32'h1,        32'h0,        1'b1, 0};
        vecs[4]  = '{OP_MADDU, 32'h1,        32'h1,        32'h0, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b1, 1};
        vecs[5]  = '{OP_MADD,  32'hFFFFFFFF, 32'h3,        32'h0, 32'h5,        32'h0,        32'h2,        1'b1, 1};
        vecs[6]  = '{OP_MSUB,  32'h2,        32'h3,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1, 1};
        vecs[7]  = '{OP_MSUBU, 32'hFFFFFFFF, 32'h1,        32'h1, 32'h0,        32'h0,        32'h1,        1'b1, 1};
        vecs[8]  = '{OP_DIV,   32'h7,        32'hFFFFFFFE, 32'h0, 32'h0,        32'h1,        32'hFFFFFFFD, 1'b1, 33};
        vecs[9]  = '{OP_DIVU,  32'd100,      32'h0,        32'h0, 32'h0,        32'h0,        32'h0,        1'b1, 1};
        vecs[10] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h0,        32'h0,        32'h80000000, 1'b1, 33};
        vecs[11] = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'h0, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1, 33};
        vecs[12] = '{OP_DIVU,  32'hFFFFFFFF, 32'h2,        32'h0, 32'h0,        32'h1,        32'h7FFFFFFF, 1'b1, 33};
        vecs[13] = '{OP_DIVU,  32'd100,      32'd7,        32'h0, 32'h0,        32'd2,        32'd14,       1'b1, 33};
        vecs[14] = '{OP_NOP,   32'h5,        32'h6,        32'h1, 32'h2,        32'h0,        32'h0,        1'b0, 0};

        rst = 1'b1; annul = 1'b0;
        aluop = OP_MULT; reg1 = 32'h3; reg2 = 32'h4; hi_in = '0; lo_in = '0;
        #12;
        check_idle_outputs("reset");
        aluop = OP_NOP;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) apply(vecs[i], i);

        // annul in IDLE suppresses a MULT write
        aluop = OP_MULT; reg1 = 32'h3; reg2 = 32'h4; annul = 1'b1;
        @(negedge clk);
        check_idle_outputs("annul_idle");
        @(posedge clk); #1;
        annul = 1'b0; aluop = OP_NOP;

        // annul at DIV_ON iteration 10
        aluop = OP_DIV; reg1 = 32'd1000; reg2 = 32'd3;
        for (int i = 0; i < 11; i++) begin @(posedge clk); #1; end
        annul = 1'b1;
        @(negedge clk);
        check("annul_div.whilo", 64'(whilo),    64'd0);
        check("annul_div.stall", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        annul = 1'b0; aluop = OP_NOP;
        @(negedge clk);
        check("annul_div.idle_stall", 64'(stallreq), 64'd0);
        check("annul_div.idle_whilo", 64'(whilo),    64'd0);
        @(posedge clk); #1;
        apply('{OP_MULT, 32'h3, 32'h4, 32'h0, 32'h0, 32'h0, 32'd12, 1'b1, 0}, 100);

        // asynchronous reset pulse in the middle of a DIV
        aluop = OP_DIV; reg1 = 32'd1000; reg2 = 32'd3;
        for (int i = 0; i < 5; i++) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("rst_div");
        #1 rst = 1'b0; aluop = OP_NOP;
        @(negedge clk);
        check("rst_div.idle_stall", 64'(stallreq), 64'd0);
        @(posedge clk); #1;
        apply('{OP_MULT, 32'hFFFFFFFD, 32'h5, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b1, 0}, 101);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
